// File: rtl/decode_pkg.sv
// Shared MIPS definitions: opcode/funct constants, ALU control encodings
// and the decoded-control record carried into the _ID pipeline register.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } aluCtl_t;

    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       aluSrcImm;
        aluCtl_t    aluCtl;
        logic [4:0] destReg;
    } decCtl_t;

    function automatic logic signed [31:0] signExt16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two combinational read ports with write-through
// bypass, one synchronous write port, hard-wired zero register.
module regfile
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddrA,
    output logic [31:0] rdataA,
    input  logic [4:0]  raddrB,
    output logic [31:0] rdataB,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem [32];

    // Synchronous write; reset clears every register, writes to $0 are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: $0 is constant zero, a same-cycle write to the index bypasses the array
    always_comb begin
        rdataA = mem[raddrA];
        rdataB = mem[raddrB];
        if (we && (waddr == raddrA)) rdataA = wdata;
        if (we && (waddr == raddrB)) rdataB = wdata;
        if (raddrA == 5'd0) rdataA = '0;
        if (raddrB == 5'd0) rdataB = '0;
    end

endmodule

// File: rtl/decode.sv
// ID stage of the pipelined MIPS core: instruction decode, register file
// read, load-use hazard detect, branch squash and the _ID pipeline register.
module decode
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] FetchData_IF,
    input  logic        BranchTaken_EXM1,
    input  logic        RegWrite_WB,
    input  logic [4:0]  WriteReg_WB,
    input  logic [31:0] WriteData_WB,
    output logic        Jump_IDM1,
    output logic [25:0] JumpTgt_IDM1,
    output logic        AnyStall,
    output logic [31:0] RsData_ID,
    output logic [31:0] RtData_ID,
    output logic [31:0] Imm_ID,
    output logic [4:0]  Rs_ID,
    output logic [4:0]  Rt_ID,
    output logic [4:0]  DestReg_ID,
    output logic [2:0]  AluCtl_ID,
    output logic        RegWrite_ID,
    output logic        MemRead_ID,
    output logic        MemWrite_ID,
    output logic        Branch_ID,
    output logic        AluSrcImm_ID
);

    logic [5:0]  opIF;
    logic [5:0]  functIF;
    logic [4:0]  rsIF;
    logic [4:0]  rtIF;
    logic [4:0]  rdIF;
    logic [31:0] rsDataIF;
    logic [31:0] rtDataIF;
    logic        usesRtIF;
    logic        loadUseIF;
    logic        bubbleIF;
    decCtl_t     decCtl;

    assign opIF    = FetchData_IF[31:26];
    assign rsIF    = FetchData_IF[25:21];
    assign rtIF    = FetchData_IF[20:16];
    assign rdIF    = FetchData_IF[15:11];
    assign functIF = FetchData_IF[5:0];

    regfile uRegfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddrA (rsIF),
        .rdataA (rsDataIF),
        .raddrB (rtIF),
        .rdataB (rtDataIF),
        .we     (RegWrite_WB),
        .waddr  (WriteReg_WB),
        .wdata  (WriteData_WB)
    );

    // Opcode/funct decode; anything unrecognised (including J and SLL $0) stays invalid
    always_comb begin
        decCtl = '0;
        unique case (opIF)
            OP_RTYPE: begin
                decCtl.valid    = 1'b1;
                decCtl.regWrite = 1'b1;
                decCtl.destReg  = rdIF;
                case (functIF)
                    FN_ADD:  decCtl.aluCtl = ALU_ADD;
                    FN_SUB:  decCtl.aluCtl = ALU_SUB;
                    FN_AND:  decCtl.aluCtl = ALU_AND;
                    FN_OR:   decCtl.aluCtl = ALU_OR;
                    FN_SLT:  decCtl.aluCtl = ALU_SLT;
                    default: decCtl = '0;
                endcase
            end
            OP_LW: begin
                decCtl.valid     = 1'b1;
                decCtl.regWrite  = 1'b1;
                decCtl.memRead   = 1'b1;
                decCtl.aluSrcImm = 1'b1;
                decCtl.destReg   = rtIF;
            end
            OP_SW: begin
                decCtl.valid     = 1'b1;
                decCtl.memWrite  = 1'b1;
                decCtl.aluSrcImm = 1'b1;
            end
            OP_BEQ: begin
                decCtl.valid  = 1'b1;
                decCtl.branch = 1'b1;
                decCtl.aluCtl = ALU_SUB;
            end
            OP_ADDI: begin
                decCtl.valid     = 1'b1;
                decCtl.regWrite  = 1'b1;
                decCtl.aluSrcImm = 1'b1;
                decCtl.destReg   = rtIF;
            end
            default: decCtl = '0;
        endcase
    end

    // Hazard detect and jump request: purely combinational off the IF word and current _ID state
    always_comb begin
        usesRtIF  = (opIF == OP_RTYPE) || (opIF == OP_SW) || (opIF == OP_BEQ);
        loadUseIF = MemRead_ID && (DestReg_ID != 5'd0) &&
                    ((DestReg_ID == rsIF) || ((DestReg_ID == rtIF) && usesRtIF));
        AnyStall     = rst_n && loadUseIF && !BranchTaken_EXM1;
        Jump_IDM1    = rst_n && (opIF == OP_J) && !BranchTaken_EXM1;
        JumpTgt_IDM1 = FetchData_IF[25:0];
        bubbleIF     = AnyStall || BranchTaken_EXM1 || !decCtl.valid;
    end

    // ---- IF -> ID pipeline register: bubble is the all-zero record ----
    always_ff @(posedge clk) begin
        if (!rst_n || bubbleIF) begin
            RsData_ID    <= '0;
            RtData_ID    <= '0;
            Imm_ID       <= '0;
            Rs_ID        <= '0;
            Rt_ID        <= '0;
            DestReg_ID   <= '0;
            AluCtl_ID    <= '0;
            RegWrite_ID  <= 1'b0;
            MemRead_ID   <= 1'b0;
            MemWrite_ID  <= 1'b0;
            Branch_ID    <= 1'b0;
            AluSrcImm_ID <= 1'b0;
        end else begin
            RsData_ID    <= rsDataIF;
            RtData_ID    <= rtDataIF;
            Imm_ID       <= signExt16(FetchData_IF[15:0]);
            Rs_ID        <= rsIF;
            Rt_ID        <= rtIF;
            DestReg_ID   <= decCtl.destReg;
            AluCtl_ID    <= decCtl.aluCtl;
            RegWrite_ID  <= decCtl.regWrite;
            MemRead_ID   <= decCtl.memRead;
            MemWrite_ID  <= decCtl.memWrite;
            Branch_ID    <= decCtl.branch;
            AluSrcImm_ID <= decCtl.aluSrcImm;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: a driver issues instructions and
// pushes expectations from a behavioural model; monitors pop and compare.
module tb_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] FetchData_IF;
    logic        BranchTaken_EXM1;
    logic        RegWrite_WB;
    logic [4:0]  WriteReg_WB;
    logic [31:0] WriteData_WB;
    logic        Jump_IDM1;
    logic [25:0] JumpTgt_IDM1;
    logic        AnyStall;
    logic [31:0] RsData_ID, RtData_ID, Imm_ID;
    logic [4:0]  Rs_ID, Rt_ID, DestReg_ID;
    logic [2:0]  AluCtl_ID;
    logic        RegWrite_ID, MemRead_ID, MemWrite_ID, Branch_ID, AluSrcImm_ID;

    decode dut (
        .clk(clk), .rst_n(rst_n), .FetchData_IF(FetchData_IF),
        .BranchTaken_EXM1(BranchTaken_EXM1), .RegWrite_WB(RegWrite_WB),
        .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
        .Jump_IDM1(Jump_IDM1), .JumpTgt_IDM1(JumpTgt_IDM1), .AnyStall(AnyStall),
        .RsData_ID(RsData_ID), .RtData_ID(RtData_ID), .Imm_ID(Imm_ID),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .DestReg_ID(DestReg_ID), .AluCtl_ID(AluCtl_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .Branch_ID(Branch_ID), .AluSrcImm_ID(AluSrcImm_ID)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  rs, rt, dest;
        logic [2:0]  alu;
        logic        rw, mr, mw, br, ais;
    } idExp_t;

    typedef struct packed {
        logic        stall;
        logic        jump;
        logic [25:0] tgt;
    } combExp_t;

    idExp_t   idQ[$];
    combExp_t combQ[$];

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] mRegs [32];
    idExp_t      mId;
    logic        lastStall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkR(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [31:0] w;
        w = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
        return w;
    endfunction

    function automatic logic [31:0] mkI(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [31:0] w;
        w = {op, rs[4:0], rt[4:0], imm};
        return w;
    endfunction

    // Register read as seen in the cycle, including the writeback in flight
    function automatic logic [31:0] mRead(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 0) return 32'd0;
        if (we && wr == idx) return wd;
        return mRegs[idx];
    endfunction

    // Drive one cycle of IF/WB inputs, push model expectations
    task automatic step(input logic [31:0] instr, input logic bt, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd, input logic rstn);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic        usesRt, stall, legal;
        combExp_t    c;
        idExp_t      n;
        @(posedge clk);
        #2;
        FetchData_IF = instr; BranchTaken_EXM1 = bt;
        RegWrite_WB = we; WriteReg_WB = wr; WriteData_WB = wd; rst_n = rstn;

        op = instr[31:26]; fn = instr[5:0];
        rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
        usesRt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        stall  = rstn && !bt && mId.mr && (mId.dest != 0) &&
                 (mId.dest == rs || (mId.dest == rt && usesRt));
        c.stall = stall;
        c.jump  = rstn && !bt && (op == 6'h02);
        c.tgt   = instr[25:0];
        combQ.push_back(c);

        n = '0;
        legal = 1'b1;
        case (op)
            6'h00: begin
                n.rw = 1; n.dest = rd;
                if      (fn == 6'h20) n.alu = 0;
                else if (fn == 6'h22) n.alu = 1;
                else if (fn == 6'h24) n.alu = 2;
                else if (fn == 6'h25) n.alu = 3;
                else if (fn == 6'h2A) n.alu = 4;
                else legal = 0;
            end
            6'h23: begin n.rw = 1; n.mr = 1; n.ais = 1; n.dest = rt; end
            6'h2B: begin n.mw = 1; n.ais = 1; end
            6'h04: begin n.br = 1; n.alu = 1; end
            6'h08: begin n.rw = 1; n.ais = 1; n.dest = rt; end
            default: legal = 0;
        endcase
        n.rs  = rs;
        n.rt  = rt;
        n.rsd = mRead(rs, we, wr, wd);
        n.rtd = mRead(rt, we, wr, wd);
        n.imm = {{16{instr[15]}}, instr[15:0]};
        if (!rstn || !legal || stall || bt) n = '0;
        idQ.push_back(n);

        // State advance at the coming edge
        mId = n;
        lastStall = stall;
        if (!rstn) begin
            for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
        end else if (we && wr != 0) begin
            mRegs[wr] = wd;
        end
    endtask

    task automatic stepI(input logic [31:0] instr, input logic bt);
        step(instr, bt, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    // Combinational monitor: mid-cycle sample
    initial begin
        combExp_t c;
        forever begin
            @(negedge clk);
            if (combQ.size() > 0) begin
                c = combQ.pop_front();
                chk("AnyStall", {31'd0, AnyStall}, {31'd0, c.stall});
                chk("Jump_IDM1", {31'd0, Jump_IDM1}, {31'd0, c.jump});
                chk("JumpTgt_IDM1", {6'd0, JumpTgt_IDM1}, {6'd0, c.tgt});
            end
        end
    end

    // Registered monitor: sample just after the edge that loads _ID
    initial begin
        idExp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (idQ.size() > 0) begin
                e = idQ.pop_front();
                chk("RsData_ID", RsData_ID, e.rsd);
                chk("RtData_ID", RtData_ID, e.rtd);
                chk("Imm_ID", Imm_ID, e.imm);
                chk("Rs_ID", {27'd0, Rs_ID}, {27'd0, e.rs});
                chk("Rt_ID", {27'd0, Rt_ID}, {27'd0, e.rt});
                chk("DestReg_ID", {27'd0, DestReg_ID}, {27'd0, e.dest});
                chk("AluCtl_ID", {29'd0, AluCtl_ID}, {29'd0, e.alu});
                chk("ctl_ID", {27'd0, RegWrite_ID, MemRead_ID, MemWrite_ID, Branch_ID, AluSrcImm_ID},
                    {27'd0, e.rw, e.mr, e.mw, e.br, e.ais});
            end
        end
    end

    initial begin
        logic [31:0] instr;
        logic [31:0] lastInstr;
        logic [5:0]  fns [5];
        logic [5:0]  ops [6];
        int          sel;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        ops = '{6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};
        for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
        mId = '0;
        lastStall = 1'b0;
        rst_n = 1'b0; FetchData_IF = '0; BranchTaken_EXM1 = 1'b0;
        RegWrite_WB = 1'b0; WriteReg_WB = '0; WriteData_WB = '0;

        step(32'h2009_0005, 1'b0, 1'b1, 5'd3, 32'h5555_5555, 1'b0);
        step(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        stepI(32'h2009_0005, 1'b0);                                   // ADDI $9,$0,5
        step(32'h012A_5820, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1);   // ADD with bypass
        stepI(mkI(6'h23, 0, 8, 16'h0004), 1'b0);                      // LW $8
        stepI(mkR(8, 3, 2, 6'h20), 1'b0);                             // load-use stall
        stepI(mkR(8, 3, 2, 6'h20), 1'b0);                             // re-presented
        stepI(mkI(6'h23, 0, 8, 16'h0004), 1'b0);
        stepI(mkR(8, 3, 2, 6'h20), 1'b1);                             // branch wins
        stepI(32'h0800_0040, 1'b0);                                   // J
        stepI(32'h0800_0040, 1'b1);                                   // J squashed
        stepI(32'h1109_FFFE, 1'b0);                                   // BEQ
        step(32'h0, 1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b1);           // write $0
        stepI(mkR(0, 0, 4, 6'h25), 1'b0);                             // read $0
        stepI(32'hFC00_0000, 1'b0);                                   // illegal opcode
        stepI(mkI(6'h23, 0, 5, 16'h0010), 1'b0);                      // LW $5
        step(mkR(1, 5, 6, 6'h22), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);     // reset mid-stall

        lastInstr = 32'h0;
        for (int k = 0; k < 400; k++) begin
            if (lastStall) begin
                instr = lastInstr;
            end else begin
                sel = $urandom_range(0, 9);
                if (sel < 4)
                    instr = mkR($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                (sel == 3) ? 6'h00 : fns[$urandom_range(0, 4)]);
                else
                    instr = mkI(ops[$urandom_range(0, 5)], $urandom_range(0, 7),
                                $urandom_range(0, 7), 16'($urandom));
            end
            lastInstr = instr;
            step(instr, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 99) != 0));
        end
        stepI(32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        if (idQ.size() != 0 || combQ.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: idQ=%0d combQ=%0d expected 0", idQ.size(), combQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
